// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core, debug and RAM-side signals around the data-memory arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the RAM.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // Handshakes: the core holds core_* stable while core_stall is high, and an access
  // completes in the first cycle with core_req && !core_stall. A debug request is
  // accepted in a cycle with dbg_req && dbg_gnt. Read data returns with dbg_rvalid
  // exactly one cycle later.
  logic              core_req;
  logic              core_we;
  logic [3:0]        core_wstrb;
  logic [31:0]       core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_wstrb, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_wstrb, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the MEM stage and a debug/loader port.
// The debug port is compiled in only when DMEM_PORT_ARBITER_DBG_EN is defined.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus,
  output logic [1:0]           fsm_state
);

`ifdef DMEM_PORT_ARBITER_DBG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CORE_RD = 2'd1, DBG_RD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CORE_RD = 2'd1} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] core_word;
  logic              dbg_win;

  assign core_word = bus.core_addr[ADDR_W+1:2];
  assign fsm_state = rst ? 2'd0 : state;

`ifdef DMEM_PORT_ARBITER_DBG_EN
  logic [3:0] starve_cnt;
  // ">=" rather than "==" so a count that overshoots while a read finishes still forces a grant.
  assign dbg_win = bus.dbg_req && ((starve_cnt >= 4'(STARVE_MAX)) || !bus.core_req);
`else
  logic unused_dbg;
  assign dbg_win    = 1'b0;
  assign unused_dbg = ^{bus.dbg_req, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
`endif

  logic unused_addr;
  assign unused_addr = ^{bus.core_addr[31:ADDR_W+2], bus.core_addr[1:0]};

  always_comb begin
    bus.core_rdata = '0;
    bus.core_stall = 1'b0;
    bus.dbg_gnt    = 1'b0;
    bus.dbg_rvalid = 1'b0;
    bus.dbg_rdata  = '0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 4'h0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (dbg_win) begin
            bus.dbg_gnt    = 1'b1;
            bus.core_stall = bus.core_req;
            bus.mem_en     = 1'b1;
            bus.mem_we     = bus.dbg_we ? 4'hF : 4'h0;
            bus.mem_addr   = bus.dbg_addr;
            bus.mem_wdata  = bus.dbg_wdata;
          end else if (bus.core_req) begin
            bus.mem_en     = 1'b1;
            bus.mem_we     = bus.core_we ? bus.core_wstrb : 4'h0;
            bus.mem_addr   = core_word;
            bus.mem_wdata  = bus.core_wdata;
            bus.core_stall = !bus.core_we;
          end
        end
        CORE_RD: begin
          bus.core_rdata = bus.mem_rdata;
        end
`ifdef DMEM_PORT_ARBITER_DBG_EN
        DBG_RD: begin
          bus.dbg_rvalid = 1'b1;
          bus.dbg_rdata  = bus.mem_rdata;
          bus.core_stall = bus.core_req;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef DMEM_PORT_ARBITER_DBG_EN
      starve_cnt <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!dbg_win && bus.core_req && !bus.core_we) state <= CORE_RD;
`ifdef DMEM_PORT_ARBITER_DBG_EN
          if (dbg_win && !bus.dbg_we) state <= DBG_RD;
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef DMEM_PORT_ARBITER_DBG_EN
      if (bus.dbg_req && !bus.dbg_gnt)
        starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= 4'd0;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 256-word synchronous RAM.
// The debug scenarios are compiled only when DMEM_PORT_ARBITER_DBG_EN is defined.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

`ifdef DMEM_PORT_ARBITER_DBG_EN
  localparam logic DBG_BG = 1'b0;
`else
  localparam logic DBG_BG = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        fsm_state;
  int                checks = 0;
  int                failures = 0;
  logic [DATA_W-1:0] ram [0:255];

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // RAM model: byte-enabled writes, registered read when mem_we is zero
  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      if (bus.mem_we == 4'h0) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [3:0] strb,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bus.core_req   = req;
    bus.core_we    = we;
    bus.core_wstrb = strb;
    bus.core_addr  = addr;
    bus.core_wdata = wdata;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [7:0] addr,
                           input logic [31:0] wdata);
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
  endtask

  initial begin
    bus.mem_rdata = '0;
    rst = 1'b1;
    core_drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    dbg_drive(1'b1, 1'b0, 8'h0, 32'h0);
    next_cycle();
    next_cycle();
    settle();
    chk("rst_core_stall", 32'(bus.core_stall), 32'd0);
    chk("rst_mem_en",     32'(bus.mem_en),     32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
    chk("rst_core_rdata", bus.core_rdata,      32'd0);
    chk("rst_state",      32'(fsm_state),      32'd0);

    // Core full-word store then load of byte address 0x08 (word 2)
    next_cycle();
    rst = 1'b0;
    dbg_drive(DBG_BG, 1'b1, 8'h33, 32'hCAFE_F00D);
    core_drive(1'b1, 1'b1, 4'hF, 32'h0000_0008, 32'hDEAD_BEEF);
    settle();
    chk("st_stall",     32'(bus.core_stall), 32'd0);
    chk("st_mem_en",    32'(bus.mem_en),     32'd1);
    chk("st_mem_we",    32'(bus.mem_we),     32'hF);
    chk("st_mem_addr",  32'(bus.mem_addr),   32'd2);
    chk("st_mem_wdata", bus.mem_wdata,       32'hDEAD_BEEF);
    chk("st_dbg_gnt",   32'(bus.dbg_gnt),    32'd0);
    next_cycle();
    core_drive(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    settle();
    chk("ld_issue_stall",  32'(bus.core_stall), 32'd1);
    chk("ld_issue_mem_en", 32'(bus.mem_en),     32'd1);
    chk("ld_issue_mem_we", 32'(bus.mem_we),     32'd0);
    next_cycle();
    settle();
    chk("ld_ret_state",  32'(fsm_state),      32'd1);
    chk("ld_ret_stall",  32'(bus.core_stall), 32'd0);
    chk("ld_ret_rdata",  bus.core_rdata,      32'hDEAD_BEEF);
    chk("ld_ret_mem_en", 32'(bus.mem_en),     32'd0);
    chk("ld_ret_gnt",    32'(bus.dbg_gnt),    32'd0);
    chk("ld_ret_rvalid", 32'(bus.dbg_rvalid), 32'd0);

    // Upper and low address bits ignored: 0x12345409 maps to word 2
    next_cycle();
    core_drive(1'b1, 1'b0, 4'h0, 32'h1234_5409, 32'h0);
    settle();
    chk("wrap_mem_addr", 32'(bus.mem_addr),   32'd2);
    chk("wrap_stall",    32'(bus.core_stall), 32'd1);
    next_cycle();
    settle();
    chk("wrap_rdata", bus.core_rdata, 32'hDEAD_BEEF);

    // Byte-strobe store merges into an existing word
    next_cycle();
    core_drive(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
    next_cycle();
    core_drive(1'b1, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00);
    settle();
    chk("strb_mem_we", 32'(bus.mem_we),     32'h2);
    chk("strb_stall",  32'(bus.core_stall), 32'd0);
    next_cycle();
    core_drive(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    settle();
    chk("strb_ld_stall", 32'(bus.core_stall), 32'd1);
    next_cycle();
    settle();
    chk("strb_ld_rdata", bus.core_rdata,      32'h1122_AB44);
    chk("strb_ld_stall2", 32'(bus.core_stall), 32'd0);

    next_cycle();
    core_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    settle();
    chk("idle_stall",  32'(bus.core_stall), 32'd0);
    chk("idle_mem_en", 32'(bus.mem_en),     32'd0);
    chk("idle_gnt",    32'(bus.dbg_gnt),    32'd0);

`ifdef DMEM_PORT_ARBITER_DBG_EN
    // Debug writes 5,1,4,2,8 to words 2..6 with the core idle
    begin
      logic [31:0] vals [0:4];
      vals[0] = 32'd5; vals[1] = 32'd1; vals[2] = 32'd4; vals[3] = 32'd2; vals[4] = 32'd8;
      for (int i = 0; i < 5; i++) begin
        next_cycle();
        dbg_drive(1'b1, 1'b1, 8'(i + 2), vals[i]);
        settle();
        chk("dw_gnt",      32'(bus.dbg_gnt),  32'd1);
        chk("dw_mem_we",   32'(bus.mem_we),   32'hF);
        chk("dw_mem_addr", 32'(bus.mem_addr), 32'(i + 2));
      end
    end
    next_cycle();
    dbg_drive(1'b1, 1'b0, 8'd4, 32'h0);
    settle();
    chk("dr_gnt",    32'(bus.dbg_gnt), 32'd1);
    chk("dr_mem_we", 32'(bus.mem_we),  32'd0);
    next_cycle();
    dbg_drive(1'b0, 1'b0, 8'd0, 32'h0);
    settle();
    chk("dr_state",  32'(fsm_state),      32'd2);
    chk("dr_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    chk("dr_rdata",  bus.dbg_rdata,       32'd4);

    // Back-to-back core loads of word 2 against a continuous debug read of word 6
    next_cycle();
    core_drive(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    dbg_drive(1'b1, 1'b0, 8'd6, 32'h0);
    settle();
    chk("sv_a_gnt",   32'(bus.dbg_gnt),    32'd0);
    chk("sv_a_stall", 32'(bus.core_stall), 32'd1);
    next_cycle();
    settle();
    chk("sv_b_rdata", bus.core_rdata,   32'd5);
    chk("sv_b_gnt",   32'(bus.dbg_gnt), 32'd0);
    next_cycle();
    settle();
    chk("sv_c_gnt",   32'(bus.dbg_gnt),    32'd0);
    chk("sv_c_stall", 32'(bus.core_stall), 32'd1);
    next_cycle();
    settle();
    chk("sv_d_state", 32'(fsm_state),   32'd1);
    chk("sv_d_gnt",   32'(bus.dbg_gnt), 32'd0);
    next_cycle();
    settle();
    chk("sv_e_gnt",      32'(bus.dbg_gnt),    32'd1);
    chk("sv_e_stall",    32'(bus.core_stall), 32'd1);
    chk("sv_e_mem_addr", 32'(bus.mem_addr),   32'd6);
    next_cycle();
    dbg_drive(1'b0, 1'b0, 8'd0, 32'h0);
    settle();
    chk("sv_f_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    chk("sv_f_rdata",  bus.dbg_rdata,       32'd8);
    chk("sv_f_stall",  32'(bus.core_stall), 32'd1);
    next_cycle();
    settle();
    chk("sv_g_stall", 32'(bus.core_stall), 32'd1);
    chk("sv_g_gnt",   32'(bus.dbg_gnt),    32'd0);
    next_cycle();
    settle();
    chk("sv_h_rdata", bus.core_rdata,      32'd5);
    chk("sv_h_stall", 32'(bus.core_stall), 32'd0);

    // Reset while a debug read is in flight drops its data
    next_cycle();
    core_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    dbg_drive(1'b1, 1'b0, 8'd3, 32'h0);
    settle();
    chk("rr_gnt", 32'(bus.dbg_gnt), 32'd1);
    next_cycle();
    rst = 1'b1;
    settle();
    chk("rr_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    chk("rr_rdata",  bus.dbg_rdata,       32'd0);
    chk("rr_gnt2",   32'(bus.dbg_gnt),    32'd0);
    chk("rr_mem_en", 32'(bus.mem_en),     32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk("rr_state",     32'(fsm_state),      32'd0);
    chk("rr_no_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    chk("rr_fresh_gnt", 32'(bus.dbg_gnt),    32'd1);
    next_cycle();
    dbg_drive(1'b0, 1'b0, 8'd0, 32'h0);
    settle();
    chk("rr_fresh_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    chk("rr_fresh_rdata",  bus.dbg_rdata,       32'd1);
`endif

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
